reg_mem_arbiter: RTL and testbench
==================================

Name: reg_mem_arbiter

Overview:
Two-requester round-robin arbiter and sequencer for a shared single-port synchronous register memory (DATA_WIDTH x 2**ADDR_BITS). It accepts read/write commands from ports A and B and issues at most one command per cycle to the memory through registered address, data and write-enable outputs. It returns read data to the originating port with a fixed latency. It sits between two datapath clients and the memory instance, and is the only driver of the memory's addr/data_in/wen.

Parameters:
DATA_WIDTH, 8, memory word width in bits
ADDR_BITS, 5, memory address width (2**ADDR_BITS words)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
req_a  input  1  port A command request; held until gnt_a sampled high
we_a  input  1  port A: 1 = write, 0 = read
addr_a  input  ADDR_BITS  port A address
wdata_a  input  DATA_WIDTH  port A write data
gnt_a  output  1  port A command accepted this cycle (combinational)
rvalid_a  output  1  port A read data valid (one-cycle pulse)
rdata_a  output  DATA_WIDTH  port A read data
req_b, we_b, addr_b, wdata_b, gnt_b, rvalid_b, rdata_b: as port A, for port B
mem_addr  output  ADDR_BITS  to memory addr (registered)
mem_wdata  output  DATA_WIDTH  to memory data_in (registered)
mem_wen  output  1  to memory wen (registered)
mem_rdata  input  DATA_WIDTH  from memory data_out (registered inside memory)

Behaviour:
- Reset (async, rst=1): mem_addr=0, mem_wdata=0, mem_wen=0, prio=A, both read-tag pipeline stages cleared, rvalid_a=rvalid_b=0, rdata_a=rdata_b=0, gnt_a=gnt_b=0 while rst is high.
- Arbitration (cycle T, combinational):
  - Only one request present: grant that port.
  - Both present: grant the port selected by prio.
  - Neither present: no grant.
  - Never more than one gnt high in a cycle.
- prio register: on each clock edge with a grant, prio is set to the port that was not granted. With no grant, prio holds.
- Issue: on the edge ending cycle T with a grant:
  - mem_addr and mem_wdata are loaded from the granted port.
  - mem_wen is loaded with the granted port's we.
- Idle: with no grant, mem_wen=0 on the next edge; mem_addr and mem_wdata hold their values (the memory performs a harmless read).
- Memory timing: memory samples mem_* at the edge ending T+1. On a write it stores the data and clears data_out to 0. On a read, data_out is valid throughout T+2.
- Read return:
  - A 2-stage tag pipeline (valid bit + port id, read grants only) delivers rvalid_x=1 in cycle T+2 for the granting port only.
  - Fixed latency: 2 cycles from gnt to rvalid.
  - rdata_x = mem_rdata when rvalid_x=1, else 0.
  - Writes produce no rvalid.
- Throughput: one grant per cycle, back-to-back, no bubbles.
- Ordering: commands reach memory in grant order. A read granted in the cycle after a write to the same address returns the new data; no forwarding is needed.
- Requester rules: req/we/addr/wdata stay stable while req=1 and gnt=0. A port may hold req high across consecutive grants, and each gnt cycle is a separate command.
- Starvation bound: a continuously requesting port is granted within 2 cycles.
- Reset mid-operation: in-flight reads are discarded with no rvalid after reset release. prio restarts at A.

Test Plan:
- Reset: assert rst mid-cycle with req_a=1 -> all outputs 0 immediately, no gnt. Release rst -> first grant goes to A.
- Single write/read, port A: write addr 5 data 0x3C, then read addr 5 -> gnt_a in T and T+1; mem_wen=1 in T+1 with mem_addr=5; rvalid_a=1 and rdata_a=0x3C in T+3; rvalid_b stays 0.
- Contention: req_a and req_b held for 4 cycles, all reads (A addr 1, B addr 2, memory preloaded with 0x11/0x22) -> grants A,B,A,B. rvalid alternates A,B,A,B from 2 cycles after the first grant, with rdata 0x11/0x22.
- Write-then-read hazard: B writes addr 31 = 0xFF in T, A reads addr 31 in T+1 -> rvalid_a in T+3 with rdata_a=0xFF.
- Idle hold: one read of addr 7, then no requests for 3 cycles -> mem_wen=0, mem_addr stays 7, no further rvalid.
- Reset during in-flight read: grant a read in T, assert rst in T+1 -> no rvalid_a in T+2 or later until a new grant.

Source files
------------

// File: rtl/reg_mem_arbiter.sv
// Round-robin arbiter/sequencer for two clients sharing one single-port
// synchronous register memory; read data returns to the issuing port two cycles after grant.
module reg_mem_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_a,
  input  logic                  we_a,
  input  logic [ADDR_BITS-1:0]  addr_a,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  output logic                  gnt_a,
  output logic                  rvalid_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  input  logic                  req_b,
  input  logic                  we_b,
  input  logic [ADDR_BITS-1:0]  addr_b,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  output logic                  gnt_b,
  output logic                  rvalid_b,
  output logic [DATA_WIDTH-1:0] rdata_b,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wen,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_t;

  port_t                 prio_reg;
  logic                  any_gnt;
  logic                  issue_we;
  logic [ADDR_BITS-1:0]  issue_addr;
  logic [DATA_WIDTH-1:0] issue_wdata;

  // Read-tag pipeline: stage 1 tracks the command in the memory input
  // registers, stage 2 lines up with valid memory output data.
  logic s1_valid_reg;
  logic s1_port_reg;
  logic s2_valid_reg;
  logic s2_port_reg;
  logic [1:0] rvalid_vec;

  assign gnt_a = !rst && req_a && (!req_b || (prio_reg == PORT_A));
  assign gnt_b = !rst && req_b && (!req_a || (prio_reg == PORT_B));
  assign any_gnt = gnt_a || gnt_b;

  assign issue_we    = gnt_b ? we_b    : we_a;
  assign issue_addr  = gnt_b ? addr_b  : addr_a;
  assign issue_wdata = gnt_b ? wdata_b : wdata_a;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_reg     <= PORT_A;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wen      <= 1'b0;
      s1_valid_reg <= 1'b0;
      s1_port_reg  <= 1'b0;
      s2_valid_reg <= 1'b0;
      s2_port_reg  <= 1'b0;
    end else begin
      if (any_gnt) begin
        prio_reg  <= gnt_a ? PORT_B : PORT_A;
        mem_addr  <= issue_addr;
        mem_wdata <= issue_wdata;
        mem_wen   <= issue_we;
      end else begin
        // Idle: address/data hold, so the memory just performs a harmless read.
        mem_wen <= 1'b0;
      end
      s1_valid_reg <= any_gnt && !issue_we;
      s1_port_reg  <= gnt_b;
      s2_valid_reg <= s1_valid_reg;
      s2_port_reg  <= s1_port_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rvalid
      assign rvalid_vec[gi] = s2_valid_reg && (s2_port_reg == 1'(gi));
    end
  endgenerate

  assign rvalid_a = rvalid_vec[0];
  assign rvalid_b = rvalid_vec[1];
  assign rdata_a  = rvalid_a ? mem_rdata : '0;
  assign rdata_b  = rvalid_b ? mem_rdata : '0;

endmodule

// File: tb/tb_reg_mem_arbiter.sv
// Directed bench for reg_mem_arbiter with a behavioural memory and a
// read-return scoreboard (expected data/port/cycle queued at grant time).
module tb_reg_mem_arbiter;

  localparam int DW = 8;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_a, we_a, req_b, we_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic          gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [DW-1:0] rdata_a, rdata_b;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wen;
  logic [DW-1:0] mem_rdata = '0;
  logic          load;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic          port;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          sb[$];
  exp_t          e_item;
  logic [DW-1:0] mem_array [32];
  logic [DW-1:0] shadow [32];

  reg_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_BITS(AW)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int i);
    logic [DW-1:0] v;
    if (i == 1)      v = 8'h11;
    else if (i == 2) v = 8'h22;
    else             v = 8'(i * 7 + 3);
    return v;
  endfunction

  // Single-port memory: write clears data_out, read data registered.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 32; i++) mem_array[i] <= init_val(i);
    end else if (mem_wen) begin
      mem_array[mem_addr] <= mem_wdata;
      mem_rdata <= '0;
    end else begin
      mem_rdata <= mem_array[mem_addr];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      if (load) for (int i = 0; i < 32; i++) shadow[i] = init_val(i);
    end else begin
      chk("one_hot_gnt", {31'd0, gnt_a & gnt_b}, 32'd0);
      if (!rvalid_a) chk("rdata_a_idle", {24'd0, rdata_a}, 32'd0);
      if (!rvalid_b) chk("rdata_b_idle", {24'd0, rdata_b}, 32'd0);
      if (rvalid_a || rvalid_b) begin
        if (sb.size() == 0) begin
          chk("unexpected_rvalid", {30'd0, rvalid_a, rvalid_b}, 32'd0);
        end else begin
          e_item = sb.pop_front();
          chk("rv_port_a", {31'd0, rvalid_a}, {31'd0, ~e_item.port});
          chk("rv_port_b", {31'd0, rvalid_b}, {31'd0, e_item.port});
          chk("rv_data", {24'd0, (e_item.port ? rdata_b : rdata_a)}, {24'd0, e_item.data});
          chk("rv_latency", cyc, e_item.due);
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        e_item = sb.pop_front();
        chk("missing_rvalid", {30'd0, rvalid_a, rvalid_b},
            e_item.port ? 32'd1 : 32'd2);
      end
      if (gnt_a) begin
        if (we_a) shadow[addr_a] = wdata_a;
        else sb.push_back('{port: 1'b0, data: shadow[addr_a], due: cyc + 2});
      end
      if (gnt_b) begin
        if (we_b) shadow[addr_b] = wdata_b;
        else sb.push_back('{port: 1'b1, data: shadow[addr_b], due: cyc + 2});
      end
    end
  end

  initial begin
    load = 1'b1;
    rst = 1'b1;
    req_a = 1'b1; we_a = 1'b0; addr_a = 5'd3; wdata_a = '0;
    req_b = 1'b0; we_b = 1'b0; addr_b = '0;   wdata_b = '0;

    // Reset state while A requests
    @(negedge clk);
    chk("rst_gnt_a", {31'd0, gnt_a}, 32'd0);
    chk("rst_gnt_b", {31'd0, gnt_b}, 32'd0);
    chk("rst_mem_wen", {31'd0, mem_wen}, 32'd0);
    chk("rst_mem_addr", {27'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    chk("rst_rvalid", {30'd0, rvalid_a, rvalid_b}, 32'd0);
    chk("rst_rdata", {16'd0, rdata_a, rdata_b}, 32'd0);
    next_cycle();
    load = 1'b0;
    @(negedge clk);

    // Release with both requesting: A wins first
    next_cycle();
    rst = 1'b0;
    req_b = 1'b1; addr_b = 5'd4;
    @(negedge clk);
    chk("first_gnt_a", {31'd0, gnt_a}, 32'd1);
    chk("first_gnt_b", {31'd0, gnt_b}, 32'd0);
    next_cycle();
    req_a = 1'b0;
    @(negedge clk);
    chk("second_gnt_b", {31'd0, gnt_b}, 32'd1);
    next_cycle();
    req_b = 1'b0;
    repeat (3) next_cycle();

    // Reset during an in-flight read
    req_a = 1'b1; we_a = 1'b0; addr_a = 5'd9;
    @(negedge clk);
    chk("inflight_gnt_a", {31'd0, gnt_a}, 32'd1);
    next_cycle();
    #2 rst = 1'b1;
    #1;
    chk("midrst_gnt_a", {31'd0, gnt_a}, 32'd0);
    chk("midrst_mem_addr", {27'd0, mem_addr}, 32'd0);
    chk("midrst_mem_wen", {31'd0, mem_wen}, 32'd0);
    chk("midrst_rvalid", {30'd0, rvalid_a, rvalid_b}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("midrst_no_rvalid_a", {31'd0, rvalid_a}, 32'd0);
      next_cycle();
    end
    rst = 1'b0;
    addr_a = 5'd10;
    req_b = 1'b1; we_b = 1'b0; addr_b = 5'd11;
    @(negedge clk);
    chk("prio_restart_gnt_a", {31'd0, gnt_a}, 32'd1);
    chk("prio_restart_gnt_b", {31'd0, gnt_b}, 32'd0);
    chk("post_rst_no_rvalid", {31'd0, rvalid_a}, 32'd0);
    next_cycle();
    req_a = 1'b0;
    @(negedge clk);
    chk("post_rst_gnt_b", {31'd0, gnt_b}, 32'd1);
    next_cycle();
    req_b = 1'b0;
    repeat (3) next_cycle();

    // Single write then read on port A
    req_a = 1'b1; we_a = 1'b1; addr_a = 5'd5; wdata_a = 8'h3C;
    @(negedge clk);
    chk("wr_gnt_a", {31'd0, gnt_a}, 32'd1);
    next_cycle();
    we_a = 1'b0;
    @(negedge clk);
    chk("rd_gnt_a", {31'd0, gnt_a}, 32'd1);
    chk("wr_mem_wen", {31'd0, mem_wen}, 32'd1);
    chk("wr_mem_addr", {27'd0, mem_addr}, 32'd5);
    chk("wr_mem_wdata", {24'd0, mem_wdata}, 32'h3C);
    next_cycle();
    req_a = 1'b0;
    @(negedge clk);
    chk("rd_mem_wen", {31'd0, mem_wen}, 32'd0);
    next_cycle();
    @(negedge clk);
    chk("rd_rvalid_a", {31'd0, rvalid_a}, 32'd1);
    chk("rd_rdata_a", {24'd0, rdata_a}, 32'h3C);
    chk("rd_rvalid_b", {31'd0, rvalid_b}, 32'd0);

    // Lone B read leaves prio at A, then contention A,B,A,B
    next_cycle();
    req_b = 1'b1; we_b = 1'b0; addr_b = 5'd2;
    @(negedge clk);
    chk("lone_gnt_b", {31'd0, gnt_b}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      if (i == 0) begin
        req_a = 1'b1; we_a = 1'b0; addr_a = 5'd1;
      end
      if (i == 4) begin
        req_a = 1'b0; req_b = 1'b0;
      end
      @(negedge clk);
      if (i < 4) begin
        chk("cont_gnt_a", {31'd0, gnt_a}, {31'd0, (i % 2 == 0)});
        chk("cont_gnt_b", {31'd0, gnt_b}, {31'd0, (i % 2 == 1)});
      end
      if (i >= 2) begin
        chk("cont_rvalid_a", {31'd0, rvalid_a}, {31'd0, (i % 2 == 0)});
        chk("cont_rvalid_b", {31'd0, rvalid_b}, {31'd0, (i % 2 == 1)});
        if (i % 2 == 0) chk("cont_rdata_a", {24'd0, rdata_a}, 32'h11);
        else            chk("cont_rdata_b", {24'd0, rdata_b}, 32'h22);
      end
    end

    // Write (B) then immediate read (A) of the same address
    next_cycle();
    req_b = 1'b1; we_b = 1'b1; addr_b = 5'd31; wdata_b = 8'hFF;
    @(negedge clk);
    chk("haz_gnt_b", {31'd0, gnt_b}, 32'd1);
    next_cycle();
    req_b = 1'b0;
    req_a = 1'b1; we_a = 1'b0; addr_a = 5'd31;
    @(negedge clk);
    chk("haz_gnt_a", {31'd0, gnt_a}, 32'd1);
    next_cycle();
    req_a = 1'b0;
    next_cycle();
    @(negedge clk);
    chk("haz_rvalid_a", {31'd0, rvalid_a}, 32'd1);
    chk("haz_rdata_a", {24'd0, rdata_a}, 32'hFF);

    // Single read then idle: address holds, no extra rvalid
    next_cycle();
    req_a = 1'b1; we_a = 1'b0; addr_a = 5'd7;
    @(negedge clk);
    chk("idle_gnt_a", {31'd0, gnt_a}, 32'd1);
    for (int j = 1; j <= 4; j++) begin
      next_cycle();
      if (j == 1) req_a = 1'b0;
      @(negedge clk);
      chk("idle_mem_wen", {31'd0, mem_wen}, 32'd0);
      chk("idle_mem_addr", {27'd0, mem_addr}, 32'd7);
      chk("idle_rvalid_a", {31'd0, rvalid_a}, {31'd0, (j == 2)});
      chk("idle_rvalid_b", {31'd0, rvalid_b}, 32'd0);
    end

    repeat (3) next_cycle();
    chk("sb_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
